// File: rtl/ex_stage_mc.sv
// Execute stage with single-cycle ALU, iterative shift-add multiplier, store path and flag register.
// Optional feature macro: EX_MUL_SIGNED_EN selects a two's-complement MUL; the default build multiplies unsigned.
module ex_stage_mc #(
  parameter int         DATA_W  = 16,
  parameter int         IR_W    = 16,
  parameter logic [4:0] OPC_MUL = 5'b01111
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec_en,
  input  logic [IR_W-1:0]   ex_ir,
  input  logic [DATA_W-1:0] reg_A,
  input  logic [DATA_W-1:0] reg_B,
  input  logic [DATA_W-1:0] smdr,
  output logic [IR_W-1:0]   mem_ir,
  output logic [DATA_W-1:0] reg_C,
  output logic              zf,
  output logic              nf,
  output logic              cf,
  output logic              dw,
  output logic [DATA_W-1:0] smdr1,
  output logic              stall
);

  // Opcode map; 5'b01111 is left free for the multiplier.
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_XOR   = 5'b10011;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SH_W  = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [IR_W-1:0]     mem_ir_q, mem_ir_d;
  logic [DATA_W-1:0]   reg_c_q, reg_c_d;
  logic [DATA_W-1:0]   smdr1_q, smdr1_d;
  logic                zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, dw_q, dw_d;
`ifdef EX_MUL_SIGNED_EN
  logic                neg_q, neg_d;
`endif

  logic [4:0]          opcode;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W:0]     alu_wide;
  logic                alu_flags;
  logic [DATA_W:0]     add_sum;
  logic [2*DATA_W-1:0] step_prod;
  logic [2*DATA_W-1:0] fin_prod;
  logic [DATA_W-1:0]   mul_lo, mul_hi;
  logic                mul_cf;
  logic [DATA_W-1:0]   a_op, b_op;

  assign opcode = ex_ir[IR_W-1 -: 5];
  assign shamt  = reg_B[SH_W-1:0];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_wide  = {1'b0, reg_B};
    alu_flags = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE:
        alu_wide = {1'b0, reg_A} + {1'b0, reg_B};
      OP_ADDC: alu_wide = {1'b0, reg_A} + {1'b0, reg_B} + {{DATA_W{1'b0}}, cf_q};
      OP_SUB, OP_SUBI, OP_CMP:
        alu_wide = {1'b0, reg_A} - {1'b0, reg_B};
      OP_SUBC: alu_wide = {1'b0, reg_A} - {1'b0, reg_B} - {{DATA_W{1'b0}}, cf_q};
      OP_AND:  alu_wide = {1'b0, reg_A & reg_B};
      OP_OR:   alu_wide = {1'b0, reg_A | reg_B};
      OP_XOR:  alu_wide = {1'b0, reg_A ^ reg_B};
      OP_SLL, OP_SLA: alu_wide = {1'b0, reg_A << shamt};
      OP_SRL:  alu_wide = {1'b0, reg_A >> shamt};
      OP_SRA:  alu_wide = {1'b0, $unsigned($signed(reg_A) >>> shamt)};
      default: alu_wide = {1'b0, reg_B};
    endcase
    case (opcode)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: alu_flags = 1'b1;
      default: alu_flags = 1'b0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
  assign add_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign step_prod = {add_sum, prod_q[DATA_W-1:1]};

`ifdef EX_MUL_SIGNED_EN
  assign a_op     = reg_A[DATA_W-1] ? -reg_A : reg_A;
  assign b_op     = reg_B[DATA_W-1] ? -reg_B : reg_B;
  assign fin_prod = neg_q ? -step_prod : step_prod;
  assign mul_lo   = fin_prod[DATA_W-1:0];
  assign mul_hi   = fin_prod[2*DATA_W-1:DATA_W];
  assign mul_cf   = (mul_hi != {DATA_W{mul_lo[DATA_W-1]}});
`else
  assign a_op     = reg_A;
  assign b_op     = reg_B;
  assign fin_prod = step_prod;
  assign mul_lo   = fin_prod[DATA_W-1:0];
  assign mul_hi   = fin_prod[2*DATA_W-1:DATA_W];
  assign mul_cf   = (mul_hi != '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    mem_ir_d = mem_ir_q;
    reg_c_d  = reg_c_q;
    smdr1_d  = smdr1_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    cf_d     = cf_q;
    dw_d     = dw_q;
    stall    = 1'b0;
`ifdef EX_MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (exec_en) begin
          if (opcode == OPC_MUL) begin
            stall    = 1'b1;
            mcand_d  = a_op;
            mplier_d = b_op;
            prod_d   = '0;
            cnt_d    = CNT_W'(DATA_W);
            mem_ir_d = '0;
            dw_d     = 1'b0;
            state_d  = S_RUN;
`ifdef EX_MUL_SIGNED_EN
            neg_d    = reg_A[DATA_W-1] ^ reg_B[DATA_W-1];
`endif
          end else begin
            mem_ir_d = ex_ir;
            reg_c_d  = alu_wide[DATA_W-1:0];
            dw_d     = (opcode == OP_STORE);
            if (opcode == OP_STORE) smdr1_d = smdr;
            if (alu_flags) begin
              zf_d = (alu_wide[DATA_W-1:0] == '0);
              nf_d = alu_wide[DATA_W-1];
              cf_d = alu_wide[DATA_W];
            end
          end
        end
      end
      S_RUN: begin
        // Stall stays high through exec_en gaps so upstream keeps holding the MUL.
        stall = (cnt_q != CNT_W'(1));
        if (exec_en) begin
          prod_d   = step_prod;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          dw_d     = 1'b0;
          if (cnt_q == CNT_W'(1)) begin
            reg_c_d  = mul_lo;
            mem_ir_d = ex_ir;
            zf_d     = (mul_lo == '0);
            nf_d     = mul_lo[DATA_W-1];
            cf_d     = mul_cf;
            state_d  = S_IDLE;
          end else begin
            mem_ir_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      mem_ir_q <= '0;
      reg_c_q  <= '0;
      smdr1_q  <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
      dw_q     <= 1'b0;
`ifdef EX_MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      mem_ir_q <= mem_ir_d;
      reg_c_q  <= reg_c_d;
      smdr1_q  <= smdr1_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      cf_q     <= cf_d;
      dw_q     <= dw_d;
`ifdef EX_MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign mem_ir = mem_ir_q;
  assign reg_C  = reg_c_q;
  assign smdr1  = smdr1_q;
  assign zf     = zf_q;
  assign nf     = nf_q;
  assign cf     = cf_q;
  assign dw     = dw_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: a reference model queues expected retirements, a monitor pops and compares them.
module tb_ex_stage_mc;

  localparam int W = 16;

  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_XOR   = 5'b10011;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         exec_en = 1'b0;
  logic [15:0]  ex_ir = '0;
  logic [W-1:0] reg_A = '0, reg_B = '0, smdr = '0;
  logic [15:0]  mem_ir;
  logic [W-1:0] reg_C, smdr1;
  logic         zf, nf, cf, dw, stall;

  ex_stage_mc dut (
    .clock(clock), .reset(reset), .exec_en(exec_en), .ex_ir(ex_ir),
    .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr),
    .mem_ir(mem_ir), .reg_C(reg_C), .zf(zf), .nf(nf), .cf(cf),
    .dw(dw), .smdr1(smdr1), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]  ir;
    logic [W-1:0] c;
    logic         zf, nf, cf, dw;
    logic [W-1:0] smdr1;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     seq = 0;
  logic   en_at_edge = 1'b0;
  logic   m_zf = 1'b0, m_nf = 1'b0, m_cf = 1'b0;
  logic [W-1:0] m_smdr1 = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: computes the retirement this instruction should produce.
  task automatic predict(input logic [4:0] op, input logic [W-1:0] a, b, s, input logic [15:0] ir);
    exp_t e;
    logic [W:0]  w;
    logic [31:0] p;
    logic signed [31:0] sa, sb;
    logic        fl;
    e.ir = ir;
    e.dw = 1'b0;
    fl   = 1'b1;
    w    = '0;
    case (op)
      OP_ADD:  w = {1'b0, a} + {1'b0, b};
      OP_ADDC: w = {1'b0, a} + {1'b0, b} + 17'(m_cf);
      OP_SUB, OP_CMP: w = {1'b0, a} - {1'b0, b};
      OP_AND:  begin w = {1'b0, a & b}; fl = 1'b0; end
      OP_XOR:  begin w = {1'b0, a ^ b}; fl = 1'b0; end
      OP_STORE: begin w = {1'b0, a} + {1'b0, b}; fl = 1'b0; e.dw = 1'b1; m_smdr1 = s; end
      OP_MUL: begin
        fl = 1'b0;
`ifdef EX_MUL_SIGNED_EN
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        p  = sa * sb;
        m_cf = (p[31:16] != {16{p[15]}});
`else
        sa = '0;
        sb = '0;
        p  = {16'h0, a} * {16'h0, b};
        m_cf = (p[31:16] != 16'h0);
`endif
        w    = {1'b0, p[15:0]};
        m_zf = (p[15:0] == 16'h0);
        m_nf = p[15];
      end
      default: fl = 1'b0;
    endcase
    if (fl) begin
      m_zf = (w[W-1:0] == '0);
      m_nf = w[W-1];
      m_cf = w[W];
    end
    e.c     = w[W-1:0];
    e.zf    = m_zf;
    e.nf    = m_nf;
    e.cf    = m_cf;
    e.smdr1 = m_smdr1;
    sb_q.push_back(e);
  endtask

  always @(posedge clock) en_at_edge = exec_en;

  // Monitor: any non-bubble mem_ir produced by an enabled edge is a retirement.
  always @(negedge clock) begin
    if (!reset && en_at_edge && mem_ir != '0) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_mem_ir", mem_ir, e.ir);
        check("sb_reg_C",  reg_C,  e.c);
        check("sb_zf",     zf,     e.zf);
        check("sb_nf",     nf,     e.nf);
        check("sb_cf",     cf,     e.cf);
        check("sb_dw",     dw,     e.dw);
        check("sb_smdr1",  smdr1,  e.smdr1);
      end
    end
  end

  // Drive one instruction from a negedge and hold it until it retires; returns at the negedge after the retire edge.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, b, s,
                        input int pause_at, input int pause_len,
                        output int cycles, output int stalls);
    logic paused, done;
    seq++;
    ex_ir   = {op, 11'(seq)};
    reg_A   = a;
    reg_B   = b;
    smdr    = s;
    exec_en = 1'b1;
    predict(op, a, b, s, ex_ir);
    cycles = 0;
    stalls = 0;
    paused = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (pause_len > 0 && !paused && stalls == pause_at) begin
        exec_en = 1'b0;
        repeat (pause_len) begin
          @(posedge clock);
          cycles++;
          @(negedge clock);
        end
        exec_en = 1'b1;
        paused  = 1'b1;
      end
      #1;
      if (stall) begin
        stalls++;
        if (stalls > 1) check("stall_mem_ir", mem_ir, 32'd0);
      end else begin
        done = 1'b1;
      end
      @(posedge clock);
      cycles++;
      @(negedge clock);
    end
    if (!done) check("retire_timeout", 32'd0, 32'd1);
    exec_en = 1'b0;
  endtask

  initial begin
    int cyc, stl;

    repeat (2) @(negedge clock);
    check("rst_mem_ir", mem_ir, 32'd0);
    check("rst_reg_C",  reg_C,  32'd0);
    check("rst_flags",  {zf, nf, cf, dw}, 32'd0);
    check("rst_smdr1",  smdr1,  32'd0);
    check("rst_stall",  stall,  32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Signed overflow boundary on a single-cycle op.
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 0, 0, cyc, stl);
    check("add_cycles", cyc, 32'd1);
    check("add_stalls", stl, 32'd0);
    check("add_reg_C",  reg_C, 32'h8000);
    check("add_zf_nf_cf", {zf, nf, cf}, 32'b010);

    run_op(OP_MUL, 16'd300, 16'd200, 16'h0, 0, 0, cyc, stl);
    check("mul1_stalls", stl, 32'd16);
    check("mul1_cycles", cyc, 32'd17);
    check("mul1_reg_C",  reg_C, 32'hEA60);
`ifndef EX_MUL_SIGNED_EN
    check("mul1_zf_nf_cf", {zf, nf, cf}, 32'b010);
`endif

    run_op(OP_MUL, 16'h1000, 16'h0010, 16'h0, 0, 0, cyc, stl);
    check("mul2_reg_C", reg_C, 32'h0000);
    check("mul2_zf_cf", {zf, cf}, 32'b11);

    run_op(OP_STORE, 16'h0001, 16'h0002, 16'hBEEF, 0, 0, cyc, stl);
    check("st_dw",    dw, 32'd1);
    check("st_smdr1", smdr1, 32'hBEEF);
    check("st_flags", {zf, nf, cf}, 32'b101);

    run_op(OP_AND, 16'hF0F0, 16'h0FF0, 16'h1234, 0, 0, cyc, stl);
    check("and_dw",    dw, 32'd0);
    check("and_smdr1", smdr1, 32'hBEEF);
    check("and_reg_C", reg_C, 32'h00F0);

    // Carry-in from MUL-set cf wraps to zero with carry out.
    run_op(OP_ADDC, 16'hFFFF, 16'h0000, 16'h0, 0, 0, cyc, stl);
    check("addc_reg_C", reg_C, 32'h0000);
    check("addc_zf_cf", {zf, cf}, 32'b11);
    run_op(OP_SUB, 16'd3, 16'd5, 16'h0, 0, 0, cyc, stl);
    run_op(OP_CMP, 16'd5, 16'd5, 16'h0, 0, 0, cyc, stl);
    run_op(OP_XOR, 16'hA5A5, 16'hFFFF, 16'h0, 0, 0, cyc, stl);

    // Back-to-back multiplies, the second with an exec_en gap mid-run.
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, 0, 0, cyc, stl);
    check("b2b1_cycles", cyc, 32'd17);
    run_op(OP_MUL, 16'd7, 16'd9, 16'h0, 5, 3, cyc, stl);
    check("pause_cycles", cyc, 32'd20);
    check("pause_stalls", stl, 32'd16);
    check("pause_reg_C",  reg_C, 32'h003F);

    run_op(OP_MUL, 16'hFFFD, 16'h0005, 16'h0, 0, 0, cyc, stl);
    check("smul_reg_C", reg_C, 32'hFFF1);
`ifdef EX_MUL_SIGNED_EN
    check("smul_nf_cf", {nf, cf}, 32'b10);
`else
    check("umul_nf_cf", {nf, cf}, 32'b11);
`endif

    // Reset five cycles into a multiply aborts it.
    ex_ir   = {OP_MUL, 11'h7FF};
    reg_A   = 16'd7;
    reg_B   = 16'd9;
    exec_en = 1'b1;
    repeat (5) @(negedge clock);
    #2;
    reset   = 1'b1;
    ex_ir   = {OP_ADD, 11'h000};
    exec_en = 1'b0;
    #1;
    check("abort_mem_ir", mem_ir, 32'd0);
    check("abort_reg_C",  reg_C,  32'd0);
    check("abort_flags",  {zf, nf, cf, dw}, 32'd0);
    check("abort_smdr1",  smdr1,  32'd0);
    check("abort_stall",  stall,  32'd0);
    m_zf = 1'b0; m_nf = 1'b0; m_cf = 1'b0; m_smdr1 = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op(OP_ADD, 16'd2, 16'd3, 16'h0, 0, 0, cyc, stl);
    check("post_rst_reg_C", reg_C, 32'h0005);
    check("post_rst_cycles", cyc, 32'd1);

    repeat (2) @(negedge clock);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised next-generation execute stage for the pipelined CPU; sits between ID and MEM.
- Single-cycle ALU ops retire in one clock, as before.
- Adds an iterative shift-add multiplier (MUL opcode) that occupies the stage for DATA_W+1 cycles and back-pressures upstream via a combinational stall.
- Carries the STORE data path (dw/smdr1) and the zf/nf/cf flag register.

Parameters:
- DATA_W, 16, datapath width of reg_A/reg_B/reg_C/smdr; ≥4.
- IR_W, 16, instruction width; opcode is ex_ir[IR_W-1:IR_W-5].
- OPC_MUL, 5'b01111, MUL opcode; must not collide with any existing opcode.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- exec_en  in  1  1 = CPU in exec state; stage advances only when high
- ex_ir  in  IR_W  instruction in EX
- reg_A  in  DATA_W  operand A
- reg_B  in  DATA_W  operand B
- smdr  in  DATA_W  store data
- mem_ir  out  IR_W  instruction passed to MEM (all-zero = bubble/NOP)
- reg_C  out  DATA_W  result register
- zf, nf, cf  out  1 each  zero/negative/carry flags
- dw  out  1  data-write strobe for MEM
- smdr1  out  DATA_W  registered store data
- stall  out  1  combinational; upstream holds ex_ir/reg_A/reg_B while high

Behaviour:
- Reset (async, high): mem_ir, reg_C, smdr1 = 0; dw, zf, nf, cf = 0; FSM = IDLE; mul counter = 0. Reset mid-multiply aborts it; no partial result retires.
- Everything holds when exec_en = 0, including a running multiply: counter and partial product freeze.
- FSM states: IDLE, RUN.
- IDLE, exec_en = 1, non-MUL opcode:
  - mem_ir <= ex_ir; reg_C <= ALU result. ALU carry-in = cf.
  - Flag ops LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP update flags: zf = (result == 0), nf = result[DATA_W-1], cf = ALU carry-out. All other ops leave flags unchanged.
  - STORE: dw <= 1, smdr1 <= smdr. Otherwise dw <= 0 and smdr1 holds.
- IDLE, exec_en = 1, MUL (issue cycle):
  - Latch multiplicand = reg_A, multiplier = reg_B; clear the 2*DATA_W partial product; cnt <= DATA_W.
  - mem_ir <= 0, dw <= 0; go to RUN.
- RUN, exec_en = 1:
  - Each cycle: one add-shift step, cnt <= cnt-1; mem_ir <= 0 and dw <= 0 while cnt > 1.
  - Final step (cnt == 1):
    - reg_C <= product[DATA_W-1:0]; mem_ir <= ex_ir (still held); dw <= 0.
    - Flags: zf = (low half == 0), nf = low[DATA_W-1], cf = (high half != 0).
    - Return to IDLE.
- stall = (IDLE & exec_en & opcode==OPC_MUL) | (RUN & cnt != 1). stall is low on the final RUN cycle so upstream advances on the retire edge.
- MUL total occupancy is DATA_W+1 active cycles: stall is high for DATA_W exec_en-high cycles; the result is visible after edge DATA_W+1.
- Back-to-back MULs: the second issues on the first IDLE cycle after retire.
- All arithmetic is modulo 2^DATA_W except the internal 2*DATA_W product.

Optional Feature:
- Macro: EX_MUL_SIGNED_EN.
- Defined:
  - MUL is two's-complement: operands are made absolute at issue, the unsigned product is negated at retire if signs differ.
  - cf = 1 iff the high half is not the sign-extension of the low half.
- Undefined: unsigned multiply as described under Behaviour.

Test Plan:
- ADD, reg_A=0x7FFF, reg_B=0x0001 -> after 1 edge reg_C=0x8000, nf=1, zf=0, cf=0, mem_ir=ex_ir, stall never high.
- MUL 300×200 -> stall high exactly 16 cycles; mem_ir=0 during those; after edge 17 reg_C=0xEA60, cf=0, nf=1, zf=0, mem_ir=MUL instruction.
- MUL 0x1000×0x0010 -> reg_C=0x0000, zf=1, cf=1; then STORE with smdr=0xBEEF -> dw=1, smdr1=0xBEEF, flags unchanged, next non-STORE gives dw=0.
- MUL 7×9 with exec_en dropped for 3 cycles mid-RUN -> retire delayed exactly 3 cycles, reg_C=0x003F.
- Assert reset 5 cycles into a MUL -> all outputs 0, stall=0 immediately; next ADD 2+3 after release gives reg_C=0x0005.
- With EX_MUL_SIGNED_EN defined: MUL 0xFFFD×0x0005 (−3×5) -> reg_C=0xFFF1, nf=1, cf=0.
